// File: rtl/uart_receiver.sv
// uart_receiver: oversampling asynchronous-serial receiver with a level/acknowledge word handoff.
// Build option UART_BREAK_DETECT_EN enables line-break reporting; without it break_o is tied 0.
module uart_receiver (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rx_i,
    input  logic [1:0]  dataBits_i,
    input  logic        hasParity_i,
    input  logic [1:0]  parityMode_i,
    input  logic        extraStopBit_i,
    input  logic [23:0] clockDivisor_i,
    input  logic        receiveReq_i,
    output logic [8:0]  dataOut_o,
    output logic        dataReceived_o,
    output logic        parityError_o,
    output logic        overflow_o,
    output logic        break_o
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_e;

    state_e      state_q;
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    logic [23:0] div_q, timer_q;
    logic [2:0]  last_bit_q, bit_q;
    logic        has_par_q, two_stop_q, stop2_q;
    logic [1:0]  par_mode_q;
    logic [7:0]  data_q;
    logic        par_q;
    logic [8:0]  dout_q;
    logic        rcv_q, perr_q, ovf_q;
`ifdef UART_BREAK_DETECT_EN
    logic        brk_q, any_one_q;
`endif

    logic        sample, exp_par;
    logic [23:0] div_eff;

    assign div_eff = (clockDivisor_i < 24'd2) ? 24'd2 : clockDivisor_i;
    // Start bit is checked at mid-bit; every later bit one full period after the previous sample.
    assign sample = (state_q == START) ? (timer_q == {1'b0, div_q[23:1]} - 24'd1)
                                       : (timer_q == div_q - 24'd1);

    always_comb begin
        exp_par = 1'b0;
        case (par_mode_q)
            2'b01:   exp_par = ^data_q;
            2'b10:   exp_par = ~^data_q;
            2'b11:   exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            div_q      <= 24'd2;
            timer_q    <= '0;
            last_bit_q <= '0;
            bit_q      <= '0;
            has_par_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
            par_mode_q <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
            dout_q     <= '0;
            rcv_q      <= 1'b0;
            perr_q     <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef UART_BREAK_DETECT_EN
            brk_q      <= 1'b0;
            any_one_q  <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            timer_q   <= timer_q + 24'd1;
            if (receiveReq_i && rcv_q) begin
                rcv_q  <= 1'b0;
                ovf_q  <= 1'b0;
                perr_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: if (rx_prev_q && !rx_sync_q) begin
                    state_q    <= START;
                    timer_q    <= '0;
                    div_q      <= div_eff;
                    last_bit_q <= 3'(dataBits_i) + 3'd4;
                    has_par_q  <= hasParity_i;
                    par_mode_q <= parityMode_i;
                    two_stop_q <= extraStopBit_i;
                    data_q     <= '0;
                    par_q      <= 1'b0;
                    bit_q      <= '0;
                    stop2_q    <= 1'b0;
`ifdef UART_BREAK_DETECT_EN
                    any_one_q  <= 1'b0;
`endif
                end
                START: if (sample) begin
                    timer_q <= '0;
                    state_q <= rx_sync_q ? IDLE : DATA;
                end
                DATA: if (sample) begin
                    timer_q       <= '0;
                    data_q[bit_q] <= rx_sync_q;
                    bit_q         <= bit_q + 3'd1;
`ifdef UART_BREAK_DETECT_EN
                    if (rx_sync_q) any_one_q <= 1'b1;
`endif
                    if (bit_q == last_bit_q) state_q <= has_par_q ? PARITY : STOP;
                end
                PARITY: if (sample) begin
                    timer_q <= '0;
                    par_q   <= rx_sync_q;
                    state_q <= STOP;
`ifdef UART_BREAK_DETECT_EN
                    if (rx_sync_q) any_one_q <= 1'b1;
`endif
                end
                STOP: if (sample) begin
                    timer_q <= '0;
                    if (!rx_sync_q) begin
                        // Framing error: frame dropped, held word left untouched.
                        state_q <= WAIT_IDLE;
`ifdef UART_BREAK_DETECT_EN
                        if (!any_one_q) brk_q <= 1'b1;
`endif
                    end else if (two_stop_q && !stop2_q) begin
                        stop2_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        dout_q  <= {par_q, data_q};
                        perr_q  <= has_par_q && (par_q != exp_par);
                        rcv_q   <= 1'b1;
                        ovf_q   <= !receiveReq_i && (ovf_q || rcv_q);
                    end
                end
                WAIT_IDLE: if (rx_sync_q) begin
                    state_q <= IDLE;
`ifdef UART_BREAK_DETECT_EN
                    brk_q   <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dataOut_o      = dout_q;
    assign dataReceived_o = rcv_q;
    assign parityError_o  = perr_q;
    assign overflow_o     = ovf_q;
`ifdef UART_BREAK_DETECT_EN
    assign break_o        = brk_q;
`else
    assign break_o        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames against a frame-level model (word/flag events scheduled from
// bit-timing arithmetic) compared every cycle, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_uart_receiver;
    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        rx = 1'b1;
    logic [1:0]  dataBits = 2'd3;
    logic        hasParity = 1'b0;
    logic [1:0]  parityMode = 2'd0;
    logic        extraStopBit = 1'b0;
    logic [23:0] clockDivisor = 24'd10;
    logic        receiveReq = 1'b0;
    logic [8:0]  dataOut;
    logic        dataReceived, parityError, overflow, brk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_ev = 0;

`ifdef UART_BREAK_DETECT_EN
    localparam bit BRK = 1'b1;
`else
    localparam bit BRK = 1'b0;
`endif

    // kind: 0 word delivered, 1 break set, 2 break cleared; cycle = first cycle the effect is visible
    typedef struct {
        int         cycle;
        int         kind;
        logic [8:0] word;
        logic       perr;
    } ev_t;
    ev_t evq[$];

    logic [8:0] m_dout;
    logic       m_rcv, m_perr, m_ovf, m_brk;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_receiver dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .rx_i           (rx),
        .dataBits_i     (dataBits),
        .hasParity_i    (hasParity),
        .parityMode_i   (parityMode),
        .extraStopBit_i (extraStopBit),
        .clockDivisor_i (clockDivisor),
        .receiveReq_i   (receiveReq),
        .dataOut_o      (dataOut),
        .dataReceived_o (dataReceived),
        .parityError_o  (parityError),
        .overflow_o     (overflow),
        .break_o        (brk)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: applies scheduled events and acknowledges at each edge.
    initial begin
        int  nc;
        bit  got, req;
        m_dout = '0; m_rcv = 0; m_perr = 0; m_ovf = 0; m_brk = 0;
        forever begin
            @(posedge clk or negedge rst_ni);
            if (!rst_ni) begin
                m_dout = '0; m_rcv = 0; m_perr = 0; m_ovf = 0; m_brk = 0;
                evq.delete();
            end else begin
                nc  = cyc + 1;
                req = receiveReq;
                got = 0;
                for (int i = evq.size() - 1; i >= 0; i--) begin
                    if (evq[i].cycle == nc) begin
                        case (evq[i].kind)
                            0: begin
                                m_dout = evq[i].word;
                                m_perr = evq[i].perr;
                                m_ovf  = !req && (m_ovf || m_rcv);
                                m_rcv  = 1;
                                got    = 1;
                            end
                            1: m_brk = 1;
                            default: m_brk = 0;
                        endcase
                        evq.delete(i);
                    end
                end
                if (!got && req && m_rcv) begin
                    m_rcv = 0; m_ovf = 0; m_perr = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("dataOut",      32'(dataOut),      32'(m_dout));
            chk("dataReceived", 32'(dataReceived), 32'(m_rcv));
            chk("parityError",  32'(parityError),  32'(m_perr));
            chk("overflow",     32'(overflow),     32'(m_ovf));
            chk("break",        32'(brk),          32'(m_brk));
        end
    end

    task automatic send_frame(input int d, input int nb, input bit pe, input bit [1:0] pm,
                              input bit es, input logic [7:0] dat, input bit flip);
        int de, n, h, k;
        logic [7:0] m;
        logic pbit;
        ev_t e;
        de = (d < 2) ? 2 : d;
        m  = dat & 8'((1 << nb) - 1);
        case (pm)
            2'b00:   pbit = 1'b0;
            2'b11:   pbit = 1'b1;
            2'b01:   pbit = 1'($countones(m) % 2);
            default: pbit = 1'(($countones(m) + 1) % 2);
        endcase
        pbit = pbit ^ flip;
        @(negedge clk);
        dataBits = 2'(nb - 5); hasParity = pe; parityMode = pm;
        extraStopBit = es; clockDivisor = 24'(d);
        @(negedge clk);
        n = cyc; h = de / 2; k = nb + int'(pe) + 1 + int'(es);
        last_ev = n + 2 + h + k * de + 1;
        e.cycle = last_ev; e.kind = 0;
        e.word  = {pe ? pbit : 1'b0, m};
        e.perr  = pe & flip;
        evq.push_back(e);
        rx = 1'b0;
        repeat (de) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            rx = m[i];
            repeat (de) @(negedge clk);
        end
        if (pe) begin
            rx = pbit;
            repeat (de) @(negedge clk);
        end
        rx = 1'b1;
        repeat (de * (1 + int'(es)) + 4) @(negedge clk);
    endtask

    task automatic ack();
        @(negedge clk); receiveReq = 1'b1;
        @(negedge clk); receiveReq = 1'b0;
    endtask

    typedef struct {
        int d; int nb; bit pe; bit [1:0] pm; bit es; logic [7:0] dat; bit flip;
    } cfg_t;
    cfg_t tbl[4];

    initial begin
        int  n, r;
        ev_t e;
        tbl[0] = '{7, 6, 1'b1, 2'b10, 1'b0, 8'h2D, 1'b0};
        tbl[1] = '{10, 7, 1'b1, 2'b11, 1'b1, 8'h55, 1'b0};
        tbl[2] = '{0, 8, 1'b0, 2'b00, 1'b0, 8'hC3, 1'b0};
        tbl[3] = '{13, 6, 1'b1, 2'b00, 1'b0, 8'hFF, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset_dout", 32'(dataOut), 32'h0);
        chk("reset_rcv",  32'(dataReceived), 32'h0);
        chk("reset_brk",  32'(brk), 32'h0);
        rst_ni = 1'b1;
        repeat (5) @(negedge clk);

        send_frame(10, 8, 1, 2'b01, 0, 8'h60, 0);
        chk("even_0x60_dout", 32'(dataOut), 32'h060);
        chk("even_0x60_perr", 32'(parityError), 32'h0);
        chk("even_0x60_rcv",  32'(dataReceived), 32'h1);
        ack();
        chk("ack_clears_rcv", 32'(dataReceived), 32'h0);

        send_frame(10, 8, 1, 2'b01, 0, 8'hA5, 1);
        chk("bad_par_dout", 32'(dataOut), 32'h1A5);
        chk("bad_par_perr", 32'(parityError), 32'h1);
        ack();

        send_frame(10, 8, 0, 2'b00, 0, 8'h11, 0);
        send_frame(10, 8, 0, 2'b00, 0, 8'h22, 0);
        chk("ovf_dout", 32'(dataOut), 32'h022);
        chk("ovf_flag", 32'(overflow), 32'h1);
        ack();
        chk("ovf_ack_rcv", 32'(dataReceived), 32'h0);
        chk("ovf_ack_ovf", 32'(overflow), 32'h0);

        send_frame(10, 5, 0, 2'b00, 1, 8'h1F, 0);
        chk("5b_2stop_dout", 32'(dataOut), 32'h01F);
        ack();

        foreach (tbl[i]) begin
            send_frame(tbl[i].d, tbl[i].nb, tbl[i].pe, tbl[i].pm, tbl[i].es, tbl[i].dat, tbl[i].flip);
            ack();
        end

        // completion coinciding with acknowledge: new word kept, no overflow
        send_frame(10, 8, 0, 2'b00, 0, 8'h44, 0);
        fork
            send_frame(10, 8, 0, 2'b00, 0, 8'h33, 0);
            begin
                repeat (3) @(negedge clk);
                for (int i = 0; i < 2000 && cyc != last_ev - 1; i++) @(negedge clk);
                receiveReq = 1'b1;
                @(negedge clk);
                receiveReq = 1'b0;
            end
        join
        chk("same_cycle_dout", 32'(dataOut), 32'h033);
        chk("same_cycle_rcv",  32'(dataReceived), 32'h1);
        chk("same_cycle_ovf",  32'(overflow), 32'h0);
        ack();

        // glitch shorter than half a bit
        @(negedge clk); rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("false_start_rcv", 32'(dataReceived), 32'h0);

        // line held low for 12 bit times
        @(negedge clk);
        dataBits = 2'd3; hasParity = 1'b0; extraStopBit = 1'b0; clockDivisor = 24'd10;
        @(negedge clk);
        n = cyc; rx = 1'b0;
        if (BRK) begin
            e.cycle = n + 2 + 5 + 9 * 10 + 1; e.kind = 1; e.word = '0; e.perr = 0;
            evq.push_back(e);
        end
        repeat (120) @(negedge clk);
        chk("break_held", 32'(brk), 32'(BRK));
        chk("break_rcv",  32'(dataReceived), 32'h0);
        r = cyc; rx = 1'b1;
        if (BRK) begin
            e.cycle = r + 3; e.kind = 2; e.word = '0; e.perr = 0;
            evq.push_back(e);
        end
        repeat (10) @(negedge clk);
        chk("break_released", 32'(brk), 32'h0);
        send_frame(10, 8, 1, 2'b01, 0, 8'h96, 0);
        chk("after_break_dout", 32'(dataOut), 32'h096);
        ack();

        // reset in the middle of a frame while a word is held
        send_frame(10, 8, 0, 2'b00, 0, 8'h5A, 0);
        @(negedge clk); rx = 1'b0;
        repeat (40) @(negedge clk);
        rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_dout", 32'(dataOut), 32'h0);
        chk("midrst_rcv",  32'(dataReceived), 32'h0);
        rst_ni = 1'b1; rx = 1'b1;
        repeat (30) @(negedge clk);
        send_frame(10, 8, 0, 2'b00, 0, 8'h3C, 0);
        chk("after_rst_dout", 32'(dataOut), 32'h03C);
        chk("after_rst_rcv",  32'(dataReceived), 32'h1);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
